// File: rtl/riscv_instr_aligner_if.sv
// Fetch-word and instruction handshake bundle for the instruction aligner.
// slave is the aligner side; master is the prefetch/decode environment.
interface riscv_instr_aligner_if;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        fetch_failed_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_compressed_o;
  logic        instr_fault_o;

  modport slave (
    input  fetch_valid_i,
    input  fetch_rdata_i,
    input  fetch_failed_i,
    input  instr_ready_i,
    output fetch_ready_o,
    output instr_valid_o,
    output instr_rdata_o,
    output instr_pc_o,
    output instr_is_compressed_o,
    output instr_fault_o
  );

  modport master (
    output fetch_valid_i,
    output fetch_rdata_i,
    output fetch_failed_i,
    output instr_ready_i,
    input  fetch_ready_o,
    input  instr_valid_o,
    input  instr_rdata_o,
    input  instr_pc_o,
    input  instr_is_compressed_o,
    input  instr_fault_o
  );
endinterface

// File: rtl/riscv_instr_aligner.sv
// Instruction aligner: splits RVC pairs and stitches straddling 32-bit
// instructions from 32-bit fetch words, one instruction per handshake.
module riscv_instr_aligner #(
  parameter bit ENABLE_RVC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] branch_addr_i,
  riscv_instr_aligner_if.slave bus
);

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HALF    = 2'd1,
    SKIP    = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_n;
  logic [31:0] pc_q;
  logic [15:0] hold_q;

  logic        valid;
  logic        fready;
  logic [31:0] rdata;
  logic        comp;
  logic        fault;
  logic [2:0]  pc_inc;
  logic        hold_ld;

  logic [31:0] word;
  logic        fv;
  logic        fail;
  logic        rdy;
  logic        hold_c;
  logic        word_c;
  logic        unused_bit0;

  assign word        = bus.fetch_rdata_i;
  assign fv          = bus.fetch_valid_i;
  assign fail        = bus.fetch_failed_i;
  assign rdy         = bus.instr_ready_i;
  assign hold_c      = hold_q[1:0] != 2'b11;
  assign word_c      = word[1:0] != 2'b11;
  assign unused_bit0 = branch_addr_i[0];

  always_comb begin
    valid   = 1'b0;
    fready  = 1'b0;
    rdata   = 32'h0;
    comp    = 1'b0;
    fault   = 1'b0;
    pc_inc  = 3'd0;
    hold_ld = 1'b0;
    state_n = state_q;
    if (!flush_i) begin
      unique case (state_q)
        ALIGNED: begin
          if (fail) begin
            fault = 1'b1;
          end else if (fv) begin
            valid  = 1'b1;
            fready = rdy;
            if (ENABLE_RVC && word_c) begin
              rdata = {16'h0, word[15:0]};
              comp  = 1'b1;
              if (rdy) begin
                pc_inc  = 3'd2;
                hold_ld = 1'b1;
                state_n = HALF;
              end
            end else begin
              rdata = word;
              if (rdy) pc_inc = 3'd4;
            end
          end
        end
        HALF: begin
          // a complete compressed half drains even past a fetch fault
          if (hold_c) begin
            valid = 1'b1;
            rdata = {16'h0, hold_q};
            comp  = 1'b1;
            if (rdy) begin
              pc_inc  = 3'd2;
              state_n = ALIGNED;
            end
          end else if (fail) begin
            fault = 1'b1;
          end else if (fv) begin
            valid  = 1'b1;
            rdata  = {word[15:0], hold_q};
            fready = rdy;
            if (rdy) begin
              pc_inc  = 3'd4;
              hold_ld = 1'b1;
            end
          end
        end
        SKIP: begin
          if (fail) begin
            fault = 1'b1;
          end else if (fv) begin
            fready  = 1'b1;
            hold_ld = 1'b1;
            state_n = HALF;
          end
        end
        default: begin
          state_n = ALIGNED;
        end
      endcase
      if (fault) valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALIGNED;
      pc_q    <= 32'h0;
      hold_q  <= 16'h0;
    end else if (flush_i) begin
      pc_q    <= {branch_addr_i[31:2],
                  ENABLE_RVC & branch_addr_i[1], 1'b0};
      hold_q  <= 16'h0;
      state_q <= (ENABLE_RVC && branch_addr_i[1]) ? SKIP : ALIGNED;
    end else begin
      pc_q    <= pc_q + {29'd0, pc_inc};
      state_q <= state_n;
      if (hold_ld) hold_q <= word[31:16];
    end
  end

  assign bus.fetch_ready_o         = fready;
  assign bus.instr_valid_o         = valid;
  assign bus.instr_rdata_o         = rdata;
  assign bus.instr_pc_o            = pc_q;
  assign bus.instr_is_compressed_o = comp;
  assign bus.instr_fault_o         = fault;

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Scoreboard bench for riscv_instr_aligner (RVC and non-RVC instances).
// Directed fetch words in, expected instruction slots queued and popped.
module tb_riscv_instr_aligner;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] pc;
    logic        c;
    logic        f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush0 = 1'b0;
  logic [31:0] baddr0 = 32'h0;
  logic        flush1 = 1'b0;
  logic [31:0] baddr1 = 32'h0;

  int checks = 0;
  int errors = 0;

  exp_t        expq[$];
  logic [31:0] words[$];

  riscv_instr_aligner_if if0 ();
  riscv_instr_aligner_if if1 ();

  riscv_instr_aligner #(.ENABLE_RVC(1'b1)) u0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush0),
    .branch_addr_i (baddr0),
    .bus           (if0.slave)
  );

  riscv_instr_aligner #(.ENABLE_RVC(1'b0)) u1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush1),
    .branch_addr_i (baddr1),
    .bus           (if1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [31:0] pc,
                              input logic c, input logic f);
    exp_t e;
    e.d = d; e.pc = pc; e.c = c; e.f = f;
    return e;
  endfunction

  // monitor: every accepted slot is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n && if0.instr_valid_o && if0.instr_ready_i) begin
      exp_t a;
      exp_t e;
      a = mk(if0.instr_rdata_o, if0.instr_pc_o,
             if0.instr_is_compressed_o, if0.instr_fault_o);
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr actual=%h/%h C%0b F%0b required=none",
                 a.d, a.pc, a.c, a.f);
      end else begin
        e = expq.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL instr actual=%h/%h C%0b F%0b required=%h/%h C%0b F%0b",
                   a.d, a.pc, a.c, a.f, e.d, e.pc, e.c, e.f);
        end
      end
    end
  end

  // fetch source: presents words[0], pops on handshake
  initial begin
    logic take;
    if0.fetch_valid_i = 1'b0;
    if0.fetch_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      take = if0.fetch_valid_i && if0.fetch_ready_o;
      @(posedge clk);
      #1;
      if (take && words.size() != 0) void'(words.pop_front());
      if0.fetch_valid_i = words.size() != 0;
      if0.fetch_rdata_i = (words.size() != 0) ? words[0] : 32'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] a);
    flush0 = 1'b1;
    baddr0 = a;
    @(negedge clk);
    chk("flush_valid", {31'd0, if0.instr_valid_o}, 32'd0);
    chk("flush_fready", {31'd0, if0.fetch_ready_o}, 32'd0);
    tick();
    flush0 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((words.size() != 0 || expq.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_in_time", {31'd0, n < 200}, 32'd1);
  endtask

  initial begin
    if0.fetch_failed_i = 1'b0;
    if0.instr_ready_i  = 1'b0;
    if1.fetch_valid_i  = 1'b0;
    if1.fetch_rdata_i  = 32'h0;
    if1.fetch_failed_i = 1'b0;
    if1.instr_ready_i  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, if0.instr_valid_o}, 32'd0);
    chk("rst_fready", {31'd0, if0.fetch_ready_o}, 32'd0);
    chk("rst_rdata", if0.instr_rdata_o, 32'd0);
    chk("rst_pc", if0.instr_pc_o, 32'd0);
    chk("rst_flags", {30'd0, if0.instr_is_compressed_o, if0.instr_fault_o},
        32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 32b then RVC pair
    if0.instr_ready_i = 1'b1;
    words.push_back(32'h00000013);
    words.push_back(32'h45010001);
    expq.push_back(mk(32'h00000013, 32'h100, 1'b0, 1'b0));
    expq.push_back(mk(32'h00000001, 32'h104, 1'b1, 1'b0));
    expq.push_back(mk(32'h00004501, 32'h106, 1'b1, 1'b0));
    do_flush(32'h100);
    drain();

    // RVC, straddling 32b, RVC
    words.push_back(32'h00130001);
    words.push_back(32'h00010000);
    expq.push_back(mk(32'h00000001, 32'h200, 1'b1, 1'b0));
    expq.push_back(mk(32'h00000013, 32'h202, 1'b0, 1'b0));
    expq.push_back(mk(32'h00000001, 32'h206, 1'b1, 1'b0));
    do_flush(32'h200);
    drain();

    // branch target at pc[1]=1: one bubble then upper half
    words.push_back(32'h00010013);
    expq.push_back(mk(32'h00000001, 32'h302, 1'b1, 1'b0));
    do_flush(32'h302);
    @(negedge clk);
    chk("skip_valid", {31'd0, if0.instr_valid_o}, 32'd0);
    chk("skip_fready", {31'd0, if0.fetch_ready_o}, 32'd1);
    tick();
    drain();

    // decode stall with a 32b word pending
    if0.instr_ready_i = 1'b0;
    words.push_back(32'h00000013);
    expq.push_back(mk(32'h00000013, 32'h600, 1'b0, 1'b0));
    do_flush(32'h600);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, if0.instr_valid_o}, 32'd1);
      chk("stall_fready", {31'd0, if0.fetch_ready_o}, 32'd0);
      chk("stall_rdata", if0.instr_rdata_o, 32'h00000013);
      chk("stall_pc", if0.instr_pc_o, 32'h600);
      tick();
    end
    if0.instr_ready_i = 1'b1;
    words.push_back(32'h00000033);
    expq.push_back(mk(32'h00000033, 32'h604, 1'b0, 1'b0));
    drain();

    // flush while a compressed half is held
    if0.instr_ready_i = 1'b0;
    words.push_back(32'h45010001);
    expq.push_back(mk(32'h00000001, 32'h700, 1'b1, 1'b0));
    do_flush(32'h700);
    tick();
    tick();
    if0.instr_ready_i = 1'b1;
    tick();
    if0.instr_ready_i = 1'b0;
    @(negedge clk);
    chk("held_valid", {31'd0, if0.instr_valid_o}, 32'd1);
    chk("held_rdata", if0.instr_rdata_o, 32'h00004501);
    chk("held_pc", if0.instr_pc_o, 32'h702);
    tick();
    words.push_back(32'h00000013);
    expq.push_back(mk(32'h00000013, 32'h500, 1'b0, 1'b0));
    if0.instr_ready_i = 1'b1;
    do_flush(32'h500);
    drain();

    // fetch fault repeats until flush
    if0.instr_ready_i = 1'b0;
    do_flush(32'h400);
    if0.fetch_failed_i = 1'b1;
    @(negedge clk);
    chk("fault_valid", {31'd0, if0.instr_valid_o}, 32'd1);
    chk("fault_flag", {31'd0, if0.instr_fault_o}, 32'd1);
    chk("fault_pc", if0.instr_pc_o, 32'h400);
    chk("fault_rdata", if0.instr_rdata_o, 32'h0);
    chk("fault_fready", {31'd0, if0.fetch_ready_o}, 32'd0);
    tick();
    expq.push_back(mk(32'h0, 32'h400, 1'b0, 1'b1));
    expq.push_back(mk(32'h0, 32'h400, 1'b0, 1'b1));
    if0.instr_ready_i = 1'b1;
    tick();
    tick();
    if0.instr_ready_i  = 1'b0;
    if0.fetch_failed_i = 1'b0;
    do_flush(32'h400);
    @(negedge clk);
    chk("postfault_valid", {31'd0, if0.instr_valid_o}, 32'd0);
    chk("postfault_flag", {31'd0, if0.instr_fault_o}, 32'd0);
    chk("fault_slots_used", expq.size(), 32'd0);
    tick();

    // non-RVC instance
    if1.fetch_valid_i = 1'b1;
    if1.fetch_rdata_i = 32'h45010001;
    if1.instr_ready_i = 1'b1;
    @(negedge clk);
    chk("norvc_rdata", if1.instr_rdata_o, 32'h45010001);
    chk("norvc_c", {31'd0, if1.instr_is_compressed_o}, 32'd0);
    chk("norvc_pc0", if1.instr_pc_o, 32'h0);
    chk("norvc_fready", {31'd0, if1.fetch_ready_o}, 32'd1);
    tick();
    if1.fetch_valid_i = 1'b0;
    @(negedge clk);
    chk("norvc_pc4", if1.instr_pc_o, 32'h4);
    tick();
    flush1 = 1'b1;
    baddr1 = 32'h302;
    tick();
    flush1 = 1'b0;
    @(negedge clk);
    chk("norvc_flush_pc", if1.instr_pc_o, 32'h300);
    tick();

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #2;
    chk("arst_pc", if0.instr_pc_o, 32'h0);
    chk("arst_valid", {31'd0, if0.instr_valid_o}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
